// File: rtl/vram_arbiter.sv
// Video RAM port arbiter: video fetches own the port whenever v_req is high,
// CPU accesses fill the free slots. Define VRAM_WBUF_EN for a posted-write buffer.
module vram_arbiter #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          v_req,
  input  logic [AW-1:0] v_addr,
  output logic [DW-1:0] v_data,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [0:0] {StIdle, StCdata} state_e;

  state_e        state_q, state_d;
  logic          op_rd_q, op_rd_d;
  logic [DW-1:0] rdata_q, rdata_d;

  assign v_data = ram_rdata;
  assign c_ack  = (state_q == StCdata);
  // Read data is live from the RAM during the ack cycle, then held in rdata_q.
  assign c_rdata = (c_ack && op_rd_q) ? ram_rdata : rdata_q;

`ifdef VRAM_WBUF_EN
  logic          buf_vld_q, buf_vld_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [DW-1:0] buf_data_q, buf_data_d;

  always_comb begin
    state_d    = state_q;
    op_rd_d    = op_rd_q;
    rdata_d    = rdata_q;
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    ram_addr   = c_addr;
    ram_we     = 1'b0;
    ram_wdata  = buf_data_q;

    unique case (state_q)
      StIdle: begin
        if (c_req && c_we && !buf_vld_q) begin
          // Writes are posted: captured even while video owns the port.
          buf_vld_d  = 1'b1;
          buf_addr_d = c_addr;
          buf_data_d = c_wdata;
          op_rd_d    = 1'b0;
          state_d    = StCdata;
        end else if (c_req && !c_we && !buf_vld_q && !v_req) begin
          // Reads wait for the buffer to drain so RAM order is preserved.
          ram_addr = c_addr;
          op_rd_d  = 1'b1;
          state_d  = StCdata;
        end
      end
      StCdata: begin
        if (op_rd_q) rdata_d = ram_rdata;
        state_d = StIdle;
      end
    endcase

    // Drain never collides with a CPU read issue: reads require an empty buffer.
    if (buf_vld_q && !v_req) begin
      ram_addr  = buf_addr_q;
      ram_we    = 1'b1;
      buf_vld_d = 1'b0;
    end

    if (v_req) begin
      ram_addr = v_addr;
      ram_we   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end
`else
  always_comb begin
    state_d   = state_q;
    op_rd_d   = op_rd_q;
    rdata_d   = rdata_q;
    ram_addr  = c_addr;
    ram_we    = 1'b0;
    ram_wdata = c_wdata;

    unique case (state_q)
      StIdle: begin
        if (c_req && !v_req) begin
          ram_addr = c_addr;
          ram_we   = c_we;
          op_rd_d  = !c_we;
          state_d  = StCdata;
        end
      end
      StCdata: begin
        if (op_rd_q) rdata_d = ram_rdata;
        state_d = StIdle;
      end
    endcase

    if (v_req) begin
      ram_addr = v_addr;
      ram_we   = 1'b0;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_rd_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_rd_q <= op_rd_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
